ram_readout_ctrl: RTL and testbench
===================================

RAM_READOUT_CTRL -- requirements
Module: ram_readout_ctrl

Interface
REQ-001 The block SHALL have parameters: ADDR_W, default 15, RAM address width; DATA_W, default 16, word width; LAST_ADDR, default 25000, highest valid buffer address; HDR_WORD, default 16'hA5C3, frame header value.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle readout request.
- start_addr  in  15  first buffer address to read.
- length  in  15  number of data words to read.
- rd_addr  out  15  RAM read address.
- rd_ena  out  1  RAM read enable.
- ram_q  in  16  RAM read data.
- ram_dval  in  1  RAM read-data valid, one cycle after rd_ena.
- tx_data  out  16  output stream word.
- tx_valid  out  1  output word valid.
- tx_ready  in  1  downstream accepts word.
- tx_sop  out  1  marks the header word.
- tx_eop  out  1  marks the trailer word.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame completion.

Function
REQ-003 The block SHALL implement states IDLE, HDR, LEN, DATA and TRL.
REQ-004 start SHALL be accepted only in IDLE; on acceptance the block latches its parameters, clears the checksum and moves to HDR; start outside IDLE SHALL be ignored.
REQ-005 A latched length above LAST_ADDR+1 SHALL be clamped to LAST_ADDR+1; a start_addr above LAST_ADDR SHALL be replaced by 0.
REQ-006 In HDR the block SHALL drive tx_data = HDR_WORD and tx_sop = 1; in LEN it SHALL drive tx_data = {1'b0, latched length}; in TRL it SHALL drive tx_data = checksum and tx_eop = 1.
REQ-007 Each state SHALL advance only on a cycle where tx_valid && tx_ready: HDR to LEN, LEN to DATA (or to TRL if length = 0), DATA to TRL after the last data word is accepted, and TRL to IDLE.
REQ-008 While tx_valid = 1 and tx_ready = 0, tx_data, tx_sop and tx_eop SHALL hold stable.
REQ-009 The DATA path SHALL use a 2-entry FIFO written by ram_q when ram_dval is high, and an inflight counter (0..2) of reads issued but not yet returned.
REQ-010 rd_ena SHALL be asserted only in DATA, with reads remaining, and when (fifo_count + inflight − pop) < 2, where pop = DATA-state word accepted this cycle.
REQ-011 This rule SHALL allow one word per cycle when tx_ready is held high and SHALL never overflow the FIFO.
REQ-012 rd_addr SHALL start at the latched start_addr, increment after each rd_ena and wrap from LAST_ADDR to 0.
REQ-013 ram_dval SHALL be ignored when inflight = 0.
REQ-014 In DATA, tx_valid SHALL equal FIFO not-empty and tx_data SHALL equal the FIFO head.
REQ-015 Checksum SHALL be the 16-bit XOR of every data word accepted in DATA.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 done SHALL pulse high for one cycle in the cycle after the trailer is accepted; a start arriving in that cycle SHALL be accepted.
REQ-018 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.

Reset
REQ-019 When rst_n = 0 at a clock edge: state = IDLE; rd_ena, tx_valid, tx_sop, tx_eop, busy and done = 0; rd_addr, tx_data and checksum = 0; FIFO and inflight cleared.
REQ-020 Reset mid-frame SHALL abort the frame without a trailer; a ram_dval arriving in the cycle after reset SHALL be discarded.

Verification
REQ-021 The bench SHALL cover each of the following scenarios:
- start_addr = 100, length = 4, RAM[100..103] = 1, 2, 3, 4, tx_ready = 1 -> stream A5C3, 0004, 0001, 0002, 0003, 0004, 0004 (XOR); sop on the first word; eop on the last; done one cycle after the last word.
- start_addr = 24998, length = 5 -> rd_addr sequence 24998, 24999, 25000, 0, 1.
- length = 0 -> stream A5C3, 0000, 0000; rd_ena never asserted.
- Random tx_ready at 30% duty, length = 1000 -> no lost or duplicated words; data stable while stalled; rd_ena never asserted while FIFO + inflight = 2.
- length = 32767 -> LEN word 61A9 (25001) and exactly 25001 data words.
- Reset asserted during DATA with one read in flight -> all outputs 0 next cycle; the stale ram_dval causes no push; a new start then produces a correct frame.

Source files
------------

// File: rtl/ram_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_readout_ctrl
// Description : Reads a window of a circular RAM buffer and emits it as a
//               framed stream: header, length, data words, XOR checksum.
//               RAM reads are prefetched through a 2-entry FIFO so the
//               stream can sustain one word per cycle under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_readout_ctrl #(
    parameter int                 ADDR_W    = 15,
    parameter int                 DATA_W    = 16,
    parameter int                 LAST_ADDR = 25000,
    parameter logic [DATA_W-1:0]  HDR_WORD  = 16'hA5C3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ena,
    input  logic [DATA_W-1:0] ram_q,
    input  logic              ram_dval,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sop,
    output logic              tx_eop,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] c_max_len   = ADDR_W'(LAST_ADDR + 1);
    localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_TRL  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ADDR_W-1:0]  r_len;
    logic [ADDR_W-1:0]  r_reads_left;
    logic [ADDR_W-1:0]  r_words_left;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [DATA_W-1:0]  r_csum;
    logic [DATA_W-1:0]  r_fifo [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_fifo_cnt;
    logic [1:0]         r_inflight;
    logic               r_done;

    logic               w_tx_valid;
    logic [DATA_W-1:0]  w_tx_data;
    logic               w_tx_sop;
    logic               w_tx_eop;
    logic               w_start_acc;
    logic               w_hs;
    logic               w_pop;
    logic               w_push;
    logic               w_rd_ena;
    logic [2:0]         w_occ;
    logic [ADDR_W-1:0]  w_len_clamp;
    logic [ADDR_W-1:0]  w_addr_clamp;

    // Out-of-range requests are folded back into the valid buffer window.
    assign w_len_clamp  = (length > c_max_len) ? c_max_len : length;
    assign w_addr_clamp = (start_addr > c_last_addr) ? '0 : start_addr;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_hs        = w_tx_valid && tx_ready;
    assign w_pop       = (r_state == ST_DATA) && w_hs;
    // A late return with nothing outstanding (e.g. right after reset) is dropped.
    assign w_push      = ram_dval && (r_inflight != 2'd0);

    // Slots already claimed after this cycle's pop; never exceeds 2, never underflows.
    assign w_occ    = {1'b0, r_fifo_cnt} + {1'b0, r_inflight} - {2'b00, w_pop};
    assign w_rd_ena = (r_state == ST_DATA) && (r_reads_left != '0) && (w_occ < 3'd2);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and stream word selection.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_valid  = 1'b0;
        w_tx_data   = '0;
        w_tx_sop    = 1'b0;
        w_tx_eop    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                w_tx_valid = 1'b1;
                w_tx_data  = HDR_WORD;
                w_tx_sop   = 1'b1;
                if (tx_ready) begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                w_tx_valid = 1'b1;
                w_tx_data  = DATA_W'(r_len);
                if (tx_ready) begin
                    w_state_nxt = (r_len == '0) ? ST_TRL : ST_DATA;
                end
            end
            ST_DATA: begin
                w_tx_valid = (r_fifo_cnt != 2'd0);
                w_tx_data  = r_fifo[r_rd_ptr];
                if ((r_fifo_cnt != 2'd0) && tx_ready && (r_words_left == c_addr_one)) begin
                    w_state_nxt = ST_TRL;
                end
            end
            ST_TRL: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_csum;
                w_tx_eop   = 1'b1;
                if (tx_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame parameters, read address walk, remaining counts and checksum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len        <= '0;
            r_reads_left <= '0;
            r_words_left <= '0;
            r_rd_addr    <= '0;
            r_csum       <= '0;
        end else if (w_start_acc) begin
            r_len        <= w_len_clamp;
            r_reads_left <= w_len_clamp;
            r_words_left <= w_len_clamp;
            r_rd_addr    <= w_addr_clamp;
            r_csum       <= '0;
        end else begin
            if (w_rd_ena) begin
                r_rd_addr    <= (r_rd_addr == c_last_addr) ? '0 : r_rd_addr + c_addr_one;
                r_reads_left <= r_reads_left - c_addr_one;
            end
            if (w_pop) begin
                r_words_left <= r_words_left - c_addr_one;
                r_csum       <= r_csum ^ r_fifo[r_rd_ptr];
            end
        end
    end

    // Two-entry prefetch FIFO fed by RAM returns.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= ram_q;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Count of reads issued to the RAM whose data has not yet returned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= 2'd0;
        end else begin
            case ({w_rd_ena, w_push})
                2'b10:   r_inflight <= r_inflight + 2'd1;
                2'b01:   r_inflight <= r_inflight - 2'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Completion pulse in the cycle after the trailer is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_TRL) && w_hs;
        end
    end

    assign rd_addr  = r_rd_addr;
    assign rd_ena   = w_rd_ena;
    assign tx_data  = w_tx_data;
    assign tx_valid = w_tx_valid;
    assign tx_sop   = w_tx_sop;
    assign tx_eop   = w_tx_eop;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_readout_ctrl
// Description : Self-checking bench for ram_readout_ctrl. A RAM model answers
//               reads one cycle later; each frame is compared against a
//               queue-based reference stream built from the buffer contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_readout_ctrl;

    localparam int LAST_ADDR = 25000;
    localparam int NWORDS    = LAST_ADDR + 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [14:0] start_addr;
    logic [14:0] length;
    logic [14:0] rd_addr;
    logic        rd_ena;
    logic [15:0] ram_q;
    logic        ram_dval;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sop;
    logic        tx_eop;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:LAST_ADDR];

    int          n_tests;
    int          n_fail;

    logic [15:0] got_d [$];
    logic [1:0]  got_f [$];
    logic [14:0] rd_seq [$];

    ram_readout_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .rd_addr    (rd_addr),
        .rd_ena     (rd_ena),
        .ram_q      (ram_q),
        .ram_dval   (ram_dval),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sop     (tx_sop),
        .tx_eop     (tx_eop),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with one cycle read latency.
    always @(posedge clk) begin
        ram_dval <= rd_ena;
        ram_q    <= (rd_addr <= 15'(LAST_ADDR)) ? mem[rd_addr] : 16'hDEAD;
    end

    // Runs one frame and checks it against the reference stream.
    task automatic run_frame(input int addr, input int len, input int duty, input bit junk,
                             input bit pre_started, input bit chain,
                             input int nxt_addr, input int nxt_len);
        int          len_c, a_c, budget, cyc, n_hs, reads, pops, occ;
        int          done_cnt, done_at, t_eop, err_stall, err_rule, err_busy, bad_idx;
        bit          pend, hs, pop, finished;
        logic [15:0] p_data, csum, d, bad_got, bad_exp;
        logic        p_sop, p_eop;
        logic [15:0] exp_d [$];
        logic [1:0]  exp_f [$];
        logic [14:0] exp_rd [$];

        len_c = (len > NWORDS) ? NWORDS : len;
        a_c   = (addr > LAST_ADDR) ? 0 : addr;
        exp_d.delete(); exp_f.delete(); exp_rd.delete();
        exp_d.push_back(16'hA5C3);  exp_f.push_back(2'b10);
        exp_d.push_back(16'(len_c)); exp_f.push_back(2'b00);
        csum = 16'h0000;
        for (int i = 0; i < len_c; i++) begin
            d = mem[(a_c + i) % NWORDS];
            exp_d.push_back(d);
            exp_f.push_back(2'b00);
            exp_rd.push_back(15'((a_c + i) % NWORDS));
            csum = csum ^ d;
        end
        exp_d.push_back(csum); exp_f.push_back(2'b01);

        got_d.delete(); got_f.delete(); rd_seq.delete();
        budget    = (duty >= 100) ? (2 * len_c + 100) : (12 * (len_c + 4) + 100);
        cyc       = pre_started ? 1 : 0;
        n_hs = 0; reads = 0; pops = 0; done_cnt = 0; done_at = -1; t_eop = -1;
        err_stall = 0; err_rule = 0; err_busy = 0;
        pend = 1'b0; finished = 1'b0;
        p_data = 16'h0; p_sop = 1'b0; p_eop = 1'b0;

        while (!finished && cyc < budget) begin
            @(negedge clk);
            if (cyc == 0) begin
                start = 1'b1; start_addr = 15'(addr); length = 15'(len);
            end else if (chain && t_eop >= 0) begin
                start = 1'b1; start_addr = 15'(nxt_addr); length = 15'(nxt_len);
            end else if (junk && busy) begin
                start = ($urandom_range(0, 3) == 0);
                start_addr = 15'($urandom); length = 15'($urandom);
            end else begin
                start = 1'b0;
            end
            tx_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            #1;
            if (pend && (tx_valid !== 1'b1 || tx_data !== p_data || tx_sop !== p_sop || tx_eop !== p_eop))
                err_stall++;
            hs  = (tx_valid === 1'b1) && tx_ready;
            pop = hs && (n_hs >= 2) && (n_hs < 2 + len_c);
            occ = reads - pops;
            if (occ > 2) err_rule++;
            if (rd_ena === 1'b1) begin
                if (occ - (pop ? 1 : 0) >= 2) err_rule++;
                rd_seq.push_back(rd_addr);
                reads++;
            end
            if (done === 1'b1) begin
                done_cnt++; done_at = cyc;
            end
            if (cyc > 0 && t_eop < 0 && busy !== 1'b1) err_busy++;
            if (t_eop >= 0 && cyc == t_eop + 1) begin
                finished = 1'b1;
                if (busy !== 1'b0 || tx_valid !== 1'b0) err_busy++;
            end
            if (hs) begin
                got_d.push_back(tx_data);
                got_f.push_back({tx_sop, tx_eop});
                n_hs++;
                if (pop) pops++;
                if (tx_eop === 1'b1 && t_eop < 0) t_eop = cyc;
            end
            pend = (tx_valid === 1'b1) && !tx_ready;
            p_data = tx_data; p_sop = tx_sop; p_eop = tx_eop;
            cyc++;
        end
        if (!chain) start = 1'b0;

        n_tests++;
        if (!finished) begin
            n_fail++;
            $display("FAIL frame_timeout: addr %0d len %0d got %0d words in %0d cycles, required frame completion",
                     addr, len, got_d.size(), cyc);
        end

        bad_idx = -1; bad_got = 16'h0; bad_exp = 16'h0;
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            if (bad_idx < 0 && (got_d[i] !== exp_d[i] || got_f[i] !== exp_f[i])) begin
                bad_idx = i; bad_got = got_d[i]; bad_exp = exp_d[i];
            end
        end
        n_tests++;
        if (got_d.size() != exp_d.size() || bad_idx >= 0) begin
            n_fail++;
            $display("FAIL stream: addr %0d len %0d words got %0d required %0d, first bad idx %0d data %h required %h",
                     addr, len, got_d.size(), exp_d.size(), bad_idx, bad_got, bad_exp);
        end

        bad_idx = -1;
        for (int i = 0; i < rd_seq.size() && i < exp_rd.size(); i++)
            if (bad_idx < 0 && rd_seq[i] !== exp_rd[i]) bad_idx = i;
        n_tests++;
        if (rd_seq.size() != exp_rd.size() || bad_idx >= 0) begin
            n_fail++;
            $display("FAIL rd_addr_seq: reads got %0d required %0d, first bad idx %0d",
                     rd_seq.size(), exp_rd.size(), bad_idx);
        end

        n_tests++;
        if (err_stall != 0) begin
            n_fail++;
            $display("FAIL stall_stable: %0d unstable stalled cycles, required 0", err_stall);
        end
        n_tests++;
        if (err_rule != 0) begin
            n_fail++;
            $display("FAIL rd_ena_rule: %0d violations, required 0", err_rule);
        end
        n_tests++;
        if (done_cnt != 1 || done_at != t_eop + 1) begin
            n_fail++;
            $display("FAIL done_pulse: count %0d at cycle %0d, required 1 at cycle %0d", done_cnt, done_at, t_eop + 1);
        end
        n_tests++;
        if (err_busy != 0) begin
            n_fail++;
            $display("FAIL busy: %0d wrong cycles, required 0", err_busy);
        end
        if (duty >= 100 && finished) begin
            n_tests++;
            if (t_eop > len_c + 8) begin
                n_fail++;
                $display("FAIL throughput: trailer at cycle %0d, required at most %0d", t_eop, len_c + 8);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (rd_ena   !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ena: got %b required 0", rd_ena); end
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
        n_tests++; if (tx_sop   !== 1'b0) begin n_fail++; $display("FAIL reset_tx_sop: got %b required 0", tx_sop); end
        n_tests++; if (tx_eop   !== 1'b0) begin n_fail++; $display("FAIL reset_tx_eop: got %b required 0", tx_eop); end
        n_tests++; if (busy     !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_tests++; if (done     !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        n_tests++; if (rd_addr  !== 15'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d required 0", rd_addr); end
        n_tests++; if (tx_data  !== 16'd0) begin n_fail++; $display("FAIL reset_tx_data: got %h required 0", tx_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] e [7];
        int          bad;
        mem[100] = 16'd1; mem[101] = 16'd2; mem[102] = 16'd3; mem[103] = 16'd4;
        run_frame(100, 4, 100, 0, 0, 0, 0, 0);
        e = '{16'hA5C3, 16'h0004, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004};
        bad = (got_d.size() != 7) ? 99 : 0;
        for (int i = 0; i < 7 && i < got_d.size(); i++) begin
            if (got_d[i] !== e[i]) bad++;
            if (got_f[i] !== ((i == 0) ? 2'b10 : (i == 6) ? 2'b01 : 2'b00)) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL basic_stream: %0d bad fields in %0d words, required 7 exact words", bad, got_d.size());
        end
    endtask

    task automatic test_wrap();
        logic [14:0] e [5];
        int          bad;
        run_frame(24998, 5, 100, 0, 0, 0, 0, 0);
        e = '{15'd24998, 15'd24999, 15'd25000, 15'd0, 15'd1};
        bad = (rd_seq.size() != 5) ? 99 : 0;
        for (int i = 0; i < 5 && i < rd_seq.size(); i++)
            if (rd_seq[i] !== e[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wrap_addrs: %0d bad of %0d reads, required 24998 24999 25000 0 1", bad, rd_seq.size());
        end
    endtask

    task automatic test_zero_len();
        run_frame(1234, 0, 100, 0, 0, 0, 0, 0);
        n_tests++;
        if (got_d.size() != 3 || got_d[0] !== 16'hA5C3 || got_d[1] !== 16'h0000 || got_d[2] !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_len_stream: %0d words, required A5C3 0000 0000", got_d.size());
        end
        n_tests++;
        if (rd_seq.size() != 0) begin
            n_fail++;
            $display("FAIL zero_len_rd_ena: got %0d reads required 0", rd_seq.size());
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2, l1, l2;
        a1 = $urandom_range(0, LAST_ADDR); l1 = $urandom_range(1, 12);
        a2 = $urandom_range(0, LAST_ADDR); l2 = $urandom_range(1, 12);
        run_frame(a1, l1, 100, 0, 0, 1, a2, l2);
        run_frame(a2, l2, 100, 0, 1, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++)
            run_frame($urandom_range(0, LAST_ADDR), $urandom_range(0, 40),
                      $urandom_range(30, 100), 1, 0, 0, 0, 0);
    endtask

    task automatic test_clamp_addr();
        run_frame(30000, 8, 70, 1, 0, 0, 0, 0);
        n_tests++;
        if (rd_seq.size() == 0 || rd_seq[0] !== 15'd0) begin
            n_fail++;
            $display("FAIL clamp_addr: first read %0d of %0d reads, required address 0",
                     (rd_seq.size() > 0) ? int'(rd_seq[0]) : -1, rd_seq.size());
        end
    endtask

    task automatic test_stall();
        run_frame($urandom_range(0, LAST_ADDR), 1000, 30, 1, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        bit fired;
        @(negedge clk);
        start = 1'b1; start_addr = 15'd500; length = 15'd50; tx_ready = 1'b1;
        fired = 1'b0; cyc = 0;
        while (!fired && cyc < 40) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (rd_ena === 1'b1 && cyc >= 4) begin
                rst_n = 1'b0; fired = 1'b1;
            end
            cyc++;
        end
        n_tests++;
        if (!fired) begin
            n_fail++;
            $display("FAIL mid_reset_setup: zero reads observed over %0d cycles, required a read in DATA", cyc);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if ({rd_ena, tx_valid, tx_sop, tx_eop, busy, done, rd_addr, tx_data} !== 37'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h required 0",
                     {rd_ena, tx_valid, tx_sop, tx_eop, busy, done, rd_addr, tx_data});
        end
        n_tests++;
        if (ram_dval !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_stale_dval: got %b required 1", ram_dval);
        end
        rst_n = 1'b1;
        run_frame($urandom_range(0, LAST_ADDR), 20, 100, 0, 0, 0, 0, 0);
    endtask

    task automatic test_max_len();
        run_frame($urandom_range(0, LAST_ADDR), 32767, 100, 0, 0, 0, 0, 0);
        n_tests++;
        if (got_d.size() < 3 || got_d[1] !== 16'h61A9 || got_d.size() - 3 != 25001) begin
            n_fail++;
            $display("FAIL max_len: LEN word %h with %0d data words, required 61A9 with 25001",
                     (got_d.size() > 1) ? got_d[1] : 16'h0, got_d.size() - 3);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i <= LAST_ADDR; i++) mem[i] = 16'($urandom);
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_back_to_back();
        test_random();
        test_clamp_addr();
        test_stall();
        test_reset_mid_frame();
        test_max_len();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
